// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 request port between the IL1 refill
// path (I) and the DL1 data path (D). One transaction is in flight at a time.
// The winner's request is registered, strobed downstream, and the L2 response
// is returned only to the owner. DL1 flushes are sequenced so that no refill
// is issued while the L2 is flushing.
// Build option: define ARB_RR_EN for round-robin arbitration on simultaneous
// requests. Without it, D has fixed priority over I.
module l2_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  // instruction refill requester
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_dout,
  output logic              i_ready,
  // data requester
  input  logic              d_en,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_din,
  output logic [DATA_W-1:0] d_dout,
  output logic              d_ready,
  input  logic              d_flush,
  output logic              d_flushed,
  // downstream L2 port
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  output logic              m_en,
  output logic              m_we,
  input  logic              m_accepting,
  input  logic [DATA_W-1:0] m_dout,
  input  logic              m_ready,
  output logic              m_flush,
  input  logic              m_flushed
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic              owner_reg;    // 1 = D owns the transaction, 0 = I
  logic              we_reg;       // registered write flag (only D can set it)
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] din_reg;
  logic [DATA_W-1:0] i_dout_reg;
  logic [DATA_W-1:0] d_dout_reg;
  logic              flushed_reg;  // L2 has acknowledged the current flush

  logic i_req;
  logic d_req;
  logic grant_d;
  logic grant;

`ifdef ARB_RR_EN
  logic rr_reg;  // 0: I wins the next tie, 1: D wins the next tie

  // Winner selection: tie broken by the round-robin pointer.
  always_comb begin
    i_req   = i_en;
    d_req   = d_en | d_we;
    grant_d = d_req & (~i_req | rr_reg);
  end

  // Round-robin pointer: flips away from the winner only on a tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_reg <= 1'b0;
    end else if (state_reg == IDLE && !d_flush && i_req && d_req) begin
      rr_reg <= ~grant_d;
    end
  end
`else
  // Winner selection: D has fixed priority over I.
  always_comb begin
    i_req   = i_en;
    d_req   = d_en | d_we;
    grant_d = d_req;
  end
`endif

  assign grant = (state_reg == IDLE) && !d_flush && (i_req || d_req);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush beats pending requests when leaving IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (d_flush) begin
          state_next = FLUSH;
        end else if (i_req || d_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (m_accepting) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (m_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      FLUSH: begin
        // Leave only once the L2 is done and the DL1 has dropped its request.
        if (flushed_reg && !d_flush) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture on grant, response capture in WAIT, flush acknowledge tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg   <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      din_reg     <= '0;
      i_dout_reg  <= '0;
      d_dout_reg  <= '0;
      flushed_reg <= 1'b0;
    end else begin
      if (grant) begin
        owner_reg <= grant_d;
        we_reg    <= grant_d & d_we;
        addr_reg  <= grant_d ? d_addr : i_addr;
        din_reg   <= grant_d ? d_din : '0;
      end
      if (state_reg == WAIT && m_ready) begin
        if (owner_reg) begin
          d_dout_reg <= m_dout;
        end else begin
          i_dout_reg <= m_dout;
        end
      end
      if (state_reg == FLUSH) begin
        if (m_flushed) begin
          flushed_reg <= 1'b1;
        end
      end else begin
        flushed_reg <= 1'b0;
      end
    end
  end

  // Output decode: strobes only in the accepting ISSUE cycle, ready only in RESP.
  always_comb begin
    m_en      = (state_reg == ISSUE) && m_accepting && !we_reg;
    m_we      = (state_reg == ISSUE) && m_accepting && we_reg;
    i_ready   = (state_reg == RESP) && !owner_reg;
    d_ready   = (state_reg == RESP) && owner_reg;
    m_flush   = (state_reg == FLUSH) && !flushed_reg;
    d_flushed = (state_reg == FLUSH) && flushed_reg && d_flush;
    m_addr    = addr_reg;
    m_din     = din_reg;
    i_dout    = i_dout_reg;
    d_dout    = d_dout_reg;
  end

endmodule
